// File: rtl/vx_rop_dcr_bank_if.sv
// DCR write bus between the command processor and the ROP configuration bank.
interface vx_rop_dcr_bank_if #(
  parameter int DCR_ADDR_BITS = 12
);
  logic                     dcr_wr_valid;
  logic                     dcr_wr_ready;
  logic [DCR_ADDR_BITS-1:0] dcr_wr_addr;
  logic [31:0]              dcr_wr_data;

  modport master (
    output dcr_wr_valid,
    output dcr_wr_addr,
    output dcr_wr_data,
    input  dcr_wr_ready
  );

  modport slave (
    input  dcr_wr_valid,
    input  dcr_wr_addr,
    input  dcr_wr_data,
    output dcr_wr_ready
  );
endinterface

// File: rtl/vx_rop_dcr_bank.sv
// ROP render-target / depth-buffer configuration bank.
// DCR writes land in a shadow copy; a COMMIT waits for the pipeline to drain
// and then copies the whole shadow into the active state in one edge.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | accepting DCR writes into the shadow
// ST_PENDING | commit accepted, writes stalled, waiting for pipe_idle
// ST_APPLY   | commit_done high, shadow copied to active at end of cycle
module vx_rop_dcr_bank #(
  parameter  int NUM_RT        = 4,
  parameter  int DCR_ADDR_BITS = 12,
  parameter  int BASE_ADDR     = 'h100,
  localparam int RT_BITS       = (NUM_RT > 1) ? $clog2(NUM_RT) : 1
) (
  input  logic               clk,
  input  logic               reset,
  vx_rop_dcr_bank_if.slave   dcr,
  input  logic               pipe_idle,
  input  logic [RT_BITS-1:0] rd_rt_idx,
  output logic [31:0]        rd_cbuf_addr,
  output logic [31:0]        rd_cbuf_pitch,
  output logic [3:0]         rd_cbuf_writemask,
  output logic [31:0]        zbuf_addr,
  output logic [31:0]        zbuf_pitch,
  output logic               commit_pending,
  output logic               commit_done,
  output logic [7:0]         state_version
);

  typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_APPLY} state_t;

  localparam logic [DCR_ADDR_BITS-1:0] BASE     = DCR_ADDR_BITS'(BASE_ADDR);
  localparam logic [DCR_ADDR_BITS-1:0] NUM_OFFS = DCR_ADDR_BITS'(7);

  state_t             state;
  logic               ready_q;
  logic [RT_BITS-1:0] rt_sel;

  logic [31:0] sh_cbuf_addr  [NUM_RT];
  logic [31:0] sh_cbuf_pitch [NUM_RT];
  logic [3:0]  sh_cbuf_wmask [NUM_RT];
  logic [31:0] sh_zbuf_addr;
  logic [31:0] sh_zbuf_pitch;

  logic [31:0] act_cbuf_addr  [NUM_RT];
  logic [31:0] act_cbuf_pitch [NUM_RT];
  logic [3:0]  act_cbuf_wmask [NUM_RT];
  logic [31:0] act_zbuf_addr;
  logic [31:0] act_zbuf_pitch;

  logic                     wr_fire;
  logic                     wr_mapped;
  logic [DCR_ADDR_BITS-1:0] wr_off;
  logic                     rd_valid;

  assign dcr.dcr_wr_ready = ready_q;

  // Address decode; anything below BASE or past the COMMIT offset is ignored.
  always_comb begin
    wr_fire   = dcr.dcr_wr_valid & ready_q;
    wr_off    = dcr.dcr_wr_addr - BASE;
    wr_mapped = wr_fire && (dcr.dcr_wr_addr >= BASE) && (wr_off < NUM_OFFS);
  end

  // Commit sequencer with registered handshake/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      ready_q        <= 1'b1;
      commit_pending <= 1'b0;
      commit_done    <= 1'b0;
      state_version  <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_mapped && wr_off == DCR_ADDR_BITS'(6)) begin
            state          <= ST_PENDING;
            ready_q        <= 1'b0;
            commit_pending <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (pipe_idle) begin
            state       <= ST_APPLY;
            commit_done <= 1'b1;
          end
        end
        ST_APPLY: begin
          state          <= ST_IDLE;
          ready_q        <= 1'b1;
          commit_pending <= 1'b0;
          commit_done    <= 1'b0;
          state_version  <= state_version + 8'd1;
        end
        default: begin
          state          <= ST_IDLE;
          ready_q        <= 1'b1;
          commit_pending <= 1'b0;
          commit_done    <= 1'b0;
        end
      endcase
    end
  end

  // Shadow register file; per-RT registers follow the current RT_SEL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rt_sel        <= '0;
      sh_zbuf_addr  <= '0;
      sh_zbuf_pitch <= '0;
      for (int i = 0; i < NUM_RT; i++) begin
        sh_cbuf_addr[i]  <= '0;
        sh_cbuf_pitch[i] <= '0;
        sh_cbuf_wmask[i] <= 4'hF;
      end
    end else if (wr_mapped) begin
      case (wr_off)
        DCR_ADDR_BITS'(0): if (dcr.dcr_wr_data < 32'(NUM_RT)) rt_sel <= dcr.dcr_wr_data[RT_BITS-1:0];
        DCR_ADDR_BITS'(1): sh_cbuf_addr[rt_sel]  <= dcr.dcr_wr_data;
        DCR_ADDR_BITS'(2): sh_cbuf_pitch[rt_sel] <= dcr.dcr_wr_data;
        DCR_ADDR_BITS'(3): sh_cbuf_wmask[rt_sel] <= dcr.dcr_wr_data[3:0];
        DCR_ADDR_BITS'(4): sh_zbuf_addr          <= dcr.dcr_wr_data;
        DCR_ADDR_BITS'(5): sh_zbuf_pitch         <= dcr.dcr_wr_data;
        default: ;
      endcase
    end
  end

  // Active state: whole shadow copied at the edge that ends APPLY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_zbuf_addr  <= '0;
      act_zbuf_pitch <= '0;
      for (int i = 0; i < NUM_RT; i++) begin
        act_cbuf_addr[i]  <= '0;
        act_cbuf_pitch[i] <= '0;
        act_cbuf_wmask[i] <= 4'hF;
      end
    end else if (state == ST_APPLY) begin
      act_zbuf_addr  <= sh_zbuf_addr;
      act_zbuf_pitch <= sh_zbuf_pitch;
      for (int i = 0; i < NUM_RT; i++) begin
        act_cbuf_addr[i]  <= sh_cbuf_addr[i];
        act_cbuf_pitch[i] <= sh_cbuf_pitch[i];
        act_cbuf_wmask[i] <= sh_cbuf_wmask[i];
      end
    end
  end

  assign rd_valid   = (int'(rd_rt_idx) < NUM_RT);
  assign zbuf_addr  = act_zbuf_addr;
  assign zbuf_pitch = act_zbuf_pitch;

  // Read port; an out-of-range render target reads as all zero.
  always_comb begin
    rd_cbuf_addr      = '0;
    rd_cbuf_pitch     = '0;
    rd_cbuf_writemask = '0;
    if (rd_valid) begin
      rd_cbuf_addr      = act_cbuf_addr[rd_rt_idx];
      rd_cbuf_pitch     = act_cbuf_pitch[rd_rt_idx];
      rd_cbuf_writemask = act_cbuf_wmask[rd_rt_idx];
    end
  end

endmodule

// File: tb/tb_vx_rop_dcr_bank.sv
// Directed bench for vx_rop_dcr_bank: stimulus pushes expected snapshots and
// commit_done versions into queues, independent monitors pop and compare.
module tb_vx_rop_dcr_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_idle;
  logic [1:0]  rd_rt_idx;
  logic [31:0] rd_cbuf_addr, rd_cbuf_pitch, zbuf_addr, zbuf_pitch;
  logic [3:0]  rd_cbuf_writemask;
  logic        commit_pending, commit_done;
  logic [7:0]  state_version;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       name;
    logic [1:0]  rt;
    logic [31:0] ca, cp;
    logic [3:0]  wm;
    logic [31:0] za, zp;
    logic        pend, rdy;
    logic [7:0]  ver;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] done_q[$];
  event       sample_ev;

  vx_rop_dcr_bank_if #(.DCR_ADDR_BITS(12)) dcr_if ();

  vx_rop_dcr_bank #(.NUM_RT(4), .DCR_ADDR_BITS(12), .BASE_ADDR('h100)) dut (
    .clk               (clk),
    .reset             (reset),
    .dcr               (dcr_if.slave),
    .pipe_idle         (pipe_idle),
    .rd_rt_idx         (rd_rt_idx),
    .rd_cbuf_addr      (rd_cbuf_addr),
    .rd_cbuf_pitch     (rd_cbuf_pitch),
    .rd_cbuf_writemask (rd_cbuf_writemask),
    .zbuf_addr         (zbuf_addr),
    .zbuf_pitch        (zbuf_pitch),
    .commit_pending    (commit_pending),
    .commit_done       (commit_done),
    .state_version     (state_version)
  );

  always #5 clk = ~clk;

  // Snapshot monitor: compares every output against the next expected entry.
  always @(sample_ev) begin
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      $display("FAIL snapshot_underflow: sample with no expectation queued");
    end else begin
      e = exp_q.pop_front();
      if (rd_cbuf_addr === e.ca && rd_cbuf_pitch === e.cp && rd_cbuf_writemask === e.wm &&
          zbuf_addr === e.za && zbuf_pitch === e.zp && commit_pending === e.pend &&
          dcr_if.dcr_wr_ready === e.rdy && state_version === e.ver)
        passed++;
      else
        $display("FAIL %s rt=%0d got ca=%h cp=%h wm=%h za=%h zp=%h pend=%b rdy=%b ver=%0d exp ca=%h cp=%h wm=%h za=%h zp=%h pend=%b rdy=%b ver=%0d",
                 e.name, e.rt, rd_cbuf_addr, rd_cbuf_pitch, rd_cbuf_writemask, zbuf_addr, zbuf_pitch,
                 commit_pending, dcr_if.dcr_wr_ready, state_version,
                 e.ca, e.cp, e.wm, e.za, e.zp, e.pend, e.rdy, e.ver);
    end
  end

  // commit_done monitor: each pulse must match a queued commit and its version.
  always @(negedge clk) begin
    if (commit_done === 1'b1) begin
      total++;
      if (done_q.size() == 0) begin
        $display("FAIL commit_done_unexpected: pulse at version %0d with none expected", state_version);
      end else begin
        logic [7:0] v;
        v = done_q.pop_front();
        if (state_version === v) passed++;
        else $display("FAIL commit_done_version got %0d exp %0d", state_version, v);
      end
    end
  end

  task automatic dcr_write(input logic [11:0] addr, input logic [31:0] data);
    int n = 0;
    dcr_if.dcr_wr_addr  = addr;
    dcr_if.dcr_wr_data  = data;
    dcr_if.dcr_wr_valid = 1'b1;
    while (dcr_if.dcr_wr_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (dcr_if.dcr_wr_ready !== 1'b1) begin
      total++;
      $display("FAIL write_ready_timeout addr=%h got ready=%b exp 1", addr, dcr_if.dcr_wr_ready);
    end
    @(posedge clk); #1;
    dcr_if.dcr_wr_valid = 1'b0;
  endtask

  task automatic woff(input int off, input logic [31:0] data);
    dcr_write(12'(12'h100 + off), data);
  endtask

  task automatic commit_wait(input logic [7:0] ver_at_done);
    done_q.push_back(ver_at_done);
    woff(6, 32'h0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic observe(input string nm, input int rt, input logic [31:0] ca, input logic [31:0] cp,
                         input logic [3:0] wm, input logic [31:0] za, input logic [31:0] zp,
                         input logic pend, input logic rdy, input logic [7:0] ver, input bit async = 1'b0);
    exp_t e;
    rd_rt_idx = rt[1:0];
    e.name = nm; e.rt = rt[1:0]; e.ca = ca; e.cp = cp; e.wm = wm;
    e.za = za; e.zp = zp; e.pend = pend; e.rdy = rdy; e.ver = ver;
    exp_q.push_back(e);
    if (async) #1;
    else @(negedge clk);
    -> sample_ev;
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    pipe_idle = 1'b1;
    rd_rt_idx = 2'd0;
    dcr_if.dcr_wr_valid = 1'b0;
    dcr_if.dcr_wr_addr  = '0;
    dcr_if.dcr_wr_data  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    observe("reset_rt0", 0, 0, 0, 4'hF, 0, 0, 0, 1, 0);
    observe("reset_rt3", 3, 0, 0, 4'hF, 0, 0, 0, 1, 0);

    // Basic commit and its minimum latency
    woff(0, 32'd2);
    woff(1, 32'h8000_0000);
    observe("shadow_hidden", 2, 0, 0, 4'hF, 0, 0, 0, 1, 0);
    done_q.push_back(8'd0);
    woff(6, 32'h0);
    observe("lat_pending", 2, 0, 0, 4'hF, 0, 0, 1, 0, 0);
    observe("lat_apply",   2, 0, 0, 4'hF, 0, 0, 1, 0, 0);
    observe("lat_visible", 2, 32'h8000_0000, 0, 4'hF, 0, 0, 0, 1, 1);
    observe("rt0_untouched", 0, 0, 0, 4'hF, 0, 0, 0, 1, 1);

    // Commit stalled by a busy pipeline
    woff(2, 32'h400);
    woff(3, 32'hFFFF_FFF5);
    woff(4, 32'h1234_0000);
    woff(5, 32'h200);
    pipe_idle = 1'b0;
    done_q.push_back(8'd1);
    woff(6, 32'h0);
    for (int i = 0; i < 10; i++)
      observe("stall_pending", 2, 32'h8000_0000, 0, 4'hF, 0, 0, 1, 0, 1);
    pipe_idle = 1'b1;
    observe("stall_apply", 2, 32'h8000_0000, 0, 4'hF, 0, 0, 1, 0, 1);
    observe("stall_done",  2, 32'h8000_0000, 32'h400, 4'h5, 32'h1234_0000, 32'h200, 0, 1, 2);

    // RT_SEL range check and unmapped addresses
    woff(0, 32'd5);
    woff(0, 32'd4);
    woff(1, 32'hAAAA_0000);
    woff(9, 32'hDEAD_BEEF);
    woff(14, 32'h0);
    dcr_write(12'h001, 32'h0000_0001);
    observe("unmapped_no_commit", 2, 32'h8000_0000, 32'h400, 4'h5, 32'h1234_0000, 32'h200, 0, 1, 2);
    woff(0, 32'd3);
    woff(1, 32'h3333_0000);
    commit_wait(8'd2);
    observe("rtsel_reject", 2, 32'hAAAA_0000, 32'h400, 4'h5, 32'h1234_0000, 32'h200, 0, 1, 3);
    observe("rtsel_max",    3, 32'h3333_0000, 0, 4'hF, 32'h1234_0000, 32'h200, 0, 1, 3);
    observe("rt1_clean",    1, 0, 0, 4'hF, 32'h1234_0000, 32'h200, 0, 1, 3);

    // Version counter wraps after 256 total commits
    for (int i = 0; i < 253; i++)
      commit_wait(8'(3 + i));
    observe("version_wrap", 2, 32'hAAAA_0000, 32'h400, 4'h5, 32'h1234_0000, 32'h200, 0, 1, 0);

    // Reset while a commit is pending
    woff(0, 32'd1);
    woff(1, 32'h5555_0000);
    pipe_idle = 1'b0;
    woff(6, 32'h0);
    observe("rst_pre", 2, 32'hAAAA_0000, 32'h400, 4'h5, 32'h1234_0000, 32'h200, 1, 0, 0);
    reset = 1'b1;
    observe("rst_async_rt2", 2, 0, 0, 4'hF, 0, 0, 0, 1, 0, 1'b1);
    observe("rst_async_rt1", 1, 0, 0, 4'hF, 0, 0, 0, 1, 0, 1'b1);
    @(posedge clk);
    #3 reset = 1'b0;
    pipe_idle = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    observe("rst_abandoned", 1, 0, 0, 4'hF, 0, 0, 0, 1, 0);

    repeat (2) @(posedge clk);
    total++;
    if (done_q.size() == 0) passed++;
    else $display("FAIL commit_done_missing got %0d pulses outstanding exp 0", done_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vx_rop_dcr_bank.md
VX_ROP_DCR_BANK -- requirements
Module: VX_rop_dcr_bank

Interface
REQ-001 The module SHALL have parameter NUM_RT, default 4, giving the number of render targets (1..8).
REQ-002 The module SHALL have parameter DCR_ADDR_BITS, default 12, giving the DCR address width.
REQ-003 The module SHALL have parameter BASE_ADDR, default 'h100, giving the DCR address of register offset 0.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 dcr_wr_valid  in  1  DCR write request.
REQ-007 dcr_wr_ready  out  1  write accepted when valid & ready.
REQ-008 dcr_wr_addr  in  DCR_ADDR_BITS  write address.
REQ-009 dcr_wr_data  in  32  write data.
REQ-010 pipe_idle  in  1  ROP pipeline drained, no fragments in flight.
REQ-011 rd_rt_idx  in  RT_BITS = max(1, clog2(NUM_RT))  render target selected for the read port.
REQ-012 rd_cbuf_addr, rd_cbuf_pitch  out  32 each  active colour-buffer state of rd_rt_idx.
REQ-013 rd_cbuf_writemask  out  4  active RGBA write mask of rd_rt_idx.
REQ-014 zbuf_addr, zbuf_pitch  out  32 each  active depth-buffer state.
REQ-015 commit_pending  out  1  a commit has been accepted and is not yet applied.
REQ-016 commit_done  out  1  one-cycle pulse in the cycle the shadow state is copied to the active state.
REQ-017 state_version  out  8  count of applied commits.

Function
REQ-018 Register offsets SHALL be: 0 RT_SEL, 1 CBUF_ADDR, 2 CBUF_PITCH, 3 CBUF_WRITEMASK (data[3:0]), 4 ZBUF_ADDR, 5 ZBUF_PITCH, 6 COMMIT.
- Offsets 1-3 write the shadow entry indexed by the current RT_SEL.
REQ-019 An RT_SEL write with data >= NUM_RT SHALL leave RT_SEL unchanged.
REQ-020 Accepted writes to unmapped offsets (7 and above, or below BASE_ADDR) SHALL be dropped without side effects.
REQ-021 A shadow write SHALL affect no output until a subsequent commit is applied.
REQ-022 The commit FSM SHALL have states IDLE, PENDING and APPLY.
- IDLE -> PENDING on an accepted COMMIT write.
- PENDING -> APPLY on the first cycle with pipe_idle=1 (pipe_idle is sampled only in PENDING).
- APPLY -> IDLE unconditionally.
REQ-023 dcr_wr_ready SHALL be 1 in IDLE and 0 in PENDING and APPLY, so the shadow is frozen while a commit is outstanding.
REQ-024 commit_pending SHALL be 1 exactly in PENDING and APPLY.
REQ-025 In APPLY, commit_done SHALL be 1, all shadow entries SHALL be copied to the active state at the clock edge ending APPLY, and state_version SHALL increment, wrapping 255 -> 0.
REQ-026 Read outputs SHALL be combinational from the active state and rd_rt_idx, and SHALL show new values in the first cycle after APPLY.
REQ-027 rd_rt_idx >= NUM_RT SHALL drive zero on all rd_* outputs.
REQ-028 The minimum commit latency SHALL be: COMMIT accepted at edge T, pipe_idle=1 in the PENDING cycle, APPLY cycle, new active state visible after edge T+2.

Reset
REQ-029 On reset assertion, all registers SHALL clear immediately regardless of clk: FSM IDLE, RT_SEL 0, state_version 0, commit_pending 0, commit_done 0, dcr_wr_ready 1.
REQ-030 On reset, all shadow and active cbuf/zbuf addresses and pitches SHALL be 0 and all writemasks SHALL be 4'hF.
REQ-031 A reset during PENDING or APPLY SHALL abandon the commit, leaving the active state at its reset values.

Verification
REQ-032 Write RT_SEL=2, CBUF_ADDR=0x8000_0000, then COMMIT with pipe_idle=1 -> rd_rt_idx=2 returns 0x8000_0000 two cycles after the COMMIT accept, state_version=1, RT0 still returns 0.
REQ-033 COMMIT with pipe_idle=0 for 10 cycles -> commit_pending=1 and dcr_wr_ready=0 throughout, active state unchanged; pipe_idle rises -> commit_done pulses once.
REQ-034 RT_SEL write of 5 with NUM_RT=4 -> RT_SEL stays at its previous value; a write to offset 9 -> no state change.
REQ-035 256 back-to-back commits -> state_version wraps to 0.
REQ-036 Assert reset mid-PENDING -> all outputs return to reset values asynchronously; CBUF_WRITEMASK reads 4'hF.
